bnn_inference_controller: RTL and testbench

// - Sequences one OCR inference per captured image: detects a full image buffer and pulses
//   bnn_start to bnn_interface.
// - Waits for a fresh result, then presents it to the downstream consumer (display/UART)

---
 rtl/bnn_inference_controller.sv | 165 ++++++++++++++++
 tb/tb_bnn_inference_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_inference_controller.sv
// bnn_inference_controller
// Runs one OCR inference for each captured image. When the image buffer is full,
// it pulses bnn_start_o and waits for a fresh result edge from bnn_interface. It
// then holds the digit on a valid/ack handshake for the consumer. After the ack
// it pulses buffer_clear_o so the buffer can refill.
//
// Optional feature: define BNN_CTRL_TIMEOUT_EN to add a WAIT_RESULT watchdog.
// When it expires, the block reports result_err_o=1 with result_out_o=4'hF.
//
// Ports
//   clk, rst             system clock; synchronous active-high reset
//   img_buffer_full_i    level, buffer holds a complete image
//   buffer_clear_o       1-cycle pulse, image consumed
//   bnn_start_o          1-cycle pulse to bnn_interface
//   bnn_result_ready_i   result_ready from bnn_interface (edge-qualified)
//   bnn_result_i         result_out from bnn_interface
//   result_valid_o       result_out_o/result_err_o valid, held until ack
//   result_out_o         classified digit (4'hF on timeout)
//   result_err_o         timeout flag
//   result_ack_i         consumer accepts result
//   busy_o               controller not idle
//   inference_count_o    completed handshakes, wrapping
module bnn_inference_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             img_buffer_full_i,
  output logic             buffer_clear_o,
  output logic             bnn_start_o,
  input  logic             bnn_result_ready_i,
  input  logic [3:0]       bnn_result_i,
  output logic             result_valid_o,
  output logic [3:0]       result_out_o,
  output logic             result_err_o,
  input  logic             result_ack_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] inference_count_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_CLEAR = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e           state_q;
  logic             rdy_q;
  logic             rdy_seen_q;
  logic             skip_full_q;
  logic             bnn_start_q;
  logic             buffer_clear_q;
  logic             result_valid_q;
  logic [3:0]       result_out_q;
  logic [CNT_W-1:0] count_q;
  logic             rise_d;

`ifdef BNN_CTRL_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMR_W-1:0] timer_q;
  logic             result_err_q;
  assign result_err_o = result_err_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^TIMEOUT_CYCLES;
  assign result_err_o = 1'b0;
`endif

  // A result is only fresh on a rising edge of ready; a level left high is stale.
  assign rise_d = bnn_result_ready_i & ~rdy_q;

  assign busy_o            = (state_q != S_IDLE);
  assign bnn_start_o       = bnn_start_q;
  assign buffer_clear_o    = buffer_clear_q;
  assign result_valid_o    = result_valid_q;
  assign result_out_o      = result_out_q;
  assign inference_count_o = count_q;

  // Sequencer: state, edge tracking and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rdy_q          <= 1'b0;
      rdy_seen_q     <= 1'b0;
      skip_full_q    <= 1'b0;
      bnn_start_q    <= 1'b0;
      buffer_clear_q <= 1'b0;
      result_valid_q <= 1'b0;
      result_out_q   <= 4'h0;
      count_q        <= '0;
`ifdef BNN_CTRL_TIMEOUT_EN
      timer_q        <= '0;
      result_err_q   <= 1'b0;
`endif
    end else begin
      rdy_q          <= bnn_result_ready_i;
      bnn_start_q    <= 1'b0;
      buffer_clear_q <= 1'b0;
      skip_full_q    <= 1'b0;

      // Remember an edge that arrives while START is still in progress.
      if (state_q == S_IDLE) begin
        rdy_seen_q <= 1'b0;
      end else if (rise_d) begin
        rdy_seen_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          // The full level may still be stale in the cycle right after a clear.
          if (img_buffer_full_i && !skip_full_q) begin
            state_q     <= S_START;
            bnn_start_q <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_WAIT;
`ifdef BNN_CTRL_TIMEOUT_EN
          timer_q <= '0;
`endif
        end
        S_WAIT: begin
          if (rise_d || rdy_seen_q) begin
            state_q        <= S_HOLD;
            result_out_q   <= bnn_result_i;
            result_valid_q <= 1'b1;
`ifdef BNN_CTRL_TIMEOUT_EN
            result_err_q   <= 1'b0;
          end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state_q        <= S_ERROR;
            result_out_q   <= 4'hF;
            result_valid_q <= 1'b1;
            result_err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
`endif
          end
        end
`ifdef BNN_CTRL_TIMEOUT_EN
        S_HOLD, S_ERROR: begin
`else
        S_HOLD: begin
`endif
          if (result_ack_i) begin
            state_q        <= S_CLEAR;
            result_valid_q <= 1'b0;
            buffer_clear_q <= 1'b1;
            count_q        <= count_q + CNT_W'(1);
          end
        end
        S_CLEAR: begin
          state_q        <= S_IDLE;
          result_valid_q <= 1'b0;
          skip_full_q    <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_inference_controller.sv
module tb_bnn_inference_controller;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned TO_CYC = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             full;
  logic             buffer_clear;
  logic             bnn_start;
  logic             ready;
  logic [3:0]       bnn_result;
  logic             valid;
  logic [3:0]       out;
  logic             err;
  logic             ack;
  logic             busy;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  bnn_inference_controller #(
    .TIMEOUT_CYCLES(TO_CYC),
    .CNT_W         (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .img_buffer_full_i (full),
    .buffer_clear_o    (buffer_clear),
    .bnn_start_o       (bnn_start),
    .bnn_result_ready_i(ready),
    .bnn_result_i      (bnn_result),
    .result_valid_o    (valid),
    .result_out_o      (out),
    .result_err_o      (err),
    .result_ack_i      (ack),
    .busy_o            (busy),
    .inference_count_o (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake completes: counter model advances modulo 2**CNT_W.
  task automatic accept_and_clear();
    ack = 1'b1;
    step();
    exp_count = (exp_count + 1) % (1 << CNT_W);
    chk("clear_pulse", 32'(buffer_clear), 1);
    chk("count", 32'(count), 32'(exp_count));
    ack = 1'b0;
    step();
    chk("clear_once", 32'(buffer_clear), 0);
    chk("valid_drop", 32'(valid), 0);
    chk("busy_idle", 32'(busy), 0);
    step();
    chk("skip_no_start", 32'(bnn_start), 0);
  endtask

  // One inference: ready rises d WAIT cycles after start; ack after hold cycles.
  task automatic run_inference(input logic [3:0] digit, input int d, input int hold,
                               input bit early_ack);
    full = 1'b1;
    step();
    chk("start_pulse", 32'(bnn_start), 1);
    chk("busy_start", 32'(busy), 1);
    full = 1'($urandom_range(0, 1));
    step();
    chk("start_once", 32'(bnn_start), 0);
    chk("wait_no_valid", 32'(valid), 0);
    for (int i = 0; i < d; i++) begin
      bnn_result = 4'($urandom);
      step();
      chk("wait_no_valid", 32'(valid), 0);
    end
    ready = 1'b1;
    bnn_result = digit;
    if (early_ack) ack = 1'b1;
    step();
    chk("valid_rise", 32'(valid), 1);
    chk("digit", 32'(out), 32'(digit));
    chk("err_clear", 32'(err), 0);
    ready = 1'b0;
    full = 1'b0;
    bnn_result = ~digit;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(valid), 1);
      chk("hold_digit", 32'(out), 32'(digit));
    end
    accept_and_clear();
  endtask

  initial begin
    logic [3:0] dg;
    rst = 1'b1; full = 1'b0; ready = 1'b0; bnn_result = 4'h0; ack = 1'b0;

    // Reset state
    step(); step();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_start", 32'(bnn_start), 0);
    chk("rst_clear", 32'(buffer_clear), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(count), 0);
    rst = 1'b0;
    step();

    // Basic run: ready 2 cycles after start, digit 7
    run_inference(4'd7, 2, 1, 1'b0);

    // Stale ready level and full held high across the clear
    dg = 4'd3;
    full = 1'b1;
    step();
    chk("s_start", 32'(bnn_start), 1);
    step();
    ready = 1'b1; bnn_result = dg;
    step();
    chk("s_valid", 32'(valid), 1);
    chk("s_digit", 32'(out), 32'(dg));
    ack = 1'b1;
    step();
    exp_count = (exp_count + 1) % (1 << CNT_W);
    chk("s_clear", 32'(buffer_clear), 1);
    chk("s_count", 32'(count), 32'(exp_count));
    ack = 1'b0;
    step();
    chk("s_idle_start", 32'(bnn_start), 0);
    chk("s_idle_busy", 32'(busy), 0);
    step();
    chk("s_skip_start", 32'(bnn_start), 0);
    chk("s_skip_busy", 32'(busy), 0);
    step();
    chk("s_restart", 32'(bnn_start), 1);
    full = 1'b0;
    bnn_result = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_stale_ignored", 32'(valid), 0);
    end
    ready = 1'b0;
    step();
    chk("s_low_no_valid", 32'(valid), 0);
    ready = 1'b1; bnn_result = 4'd5;
    step();
    chk("s_new_rise", 32'(valid), 1);
    chk("s_new_digit", 32'(out), 5);
    ready = 1'b0;
    accept_and_clear();

    // Ack withheld 50 cycles, second full ignored, then reset mid-HOLD
    full = 1'b1;
    step();
    chk("h_start", 32'(bnn_start), 1);
    step();
    ready = 1'b1; bnn_result = 4'd2;
    step();
    ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bnn_result = 4'($urandom);
      step();
      chk("h_valid", 32'(valid), 1);
      chk("h_digit", 32'(out), 2);
      chk("h_no_start", 32'(bnn_start), 0);
    end
    rst = 1'b1;
    full = 1'b0;
    step();
    exp_count = 0;
    chk("hr_valid", 32'(valid), 0);
    chk("hr_out", 32'(out), 0);
    chk("hr_busy", 32'(busy), 0);
    chk("hr_count", 32'(count), 0);
    rst = 1'b0;
    step();
    chk("hr_idle", 32'(busy), 0);

`ifdef BNN_CTRL_TIMEOUT_EN
    // Timeout: no ready at all
    full = 1'b1;
    step();
    chk("t_start", 32'(bnn_start), 1);
    full = 1'b0;
    step();
    for (int i = 0; i < int'(TO_CYC) - 1; i++) begin
      step();
      chk("t_wait", 32'(valid), 0);
    end
    step();
    chk("t_valid", 32'(valid), 1);
    chk("t_err", 32'(err), 1);
    chk("t_out", 32'(out), 32'hF);
    step();
    chk("t_hold", 32'(err), 1);
    accept_and_clear();
    // Result on the last allowed WAIT cycle wins over the timeout
    run_inference(4'd6, int'(TO_CYC) - 1, 0, 1'b0);
`else
    // No watchdog: a very late result is still accepted
    run_inference(4'd6, 60, 0, 1'b0);
    chk("no_err", 32'(err), 0);
`endif

    // Randomized runs; the counter wraps several times
    for (int n = 0; n < 16; n++) begin
      bit early;
      early = 1'($urandom_range(0, 1));
      run_inference(4'($urandom_range(0, 9)), $urandom_range(0, int'(TO_CYC) - 1),
                    early ? 0 : $urandom_range(0, 4), early);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
